vx_dxa_uop_assembler: RTL and testbench



---
 rtl/VX_gpu_pkg.sv | 30 +++
 rtl/VX_priority_encoder.sv | 24 ++
 rtl/vx_dxa_uop_assembler.sv | 167 ++++++++++++++++
 tb/tb_vx_dxa_uop_assembler.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/VX_gpu_pkg.sv
// Shared DXA definitions: launch micro-op codes and the packed engine request
// record used for both the staging and the output registers.
package VX_gpu_pkg;

    localparam int DXA_NUM_LANES  = 4;
    localparam int DXA_XLEN       = 32;
    localparam int DXA_NW_WIDTH   = 4;
    localparam int DXA_UUID_WIDTH = 44;
    localparam int DXA_FLAGS_W    = 16;
    localparam int DXA_NUM_COORDS = 5;

    // Op codes carried in op_args[2:0]; the uop expander emits them in this order.
    localparam logic [2:0] DXA_OP_SETUP0  = 3'd0;
    localparam logic [2:0] DXA_OP_SETUP1  = 3'd1;
    localparam logic [2:0] DXA_OP_COORD01 = 3'd2;
    localparam logic [2:0] DXA_OP_COORD23 = 3'd3;
    localparam logic [2:0] DXA_OP_ISSUE   = 3'd4;

    typedef struct packed {
        logic [DXA_NW_WIDTH-1:0]                  wid;
        logic [DXA_UUID_WIDTH-1:0]                uuid;
        logic [DXA_NUM_LANES-1:0]                 tmask;
        logic [DXA_XLEN-1:0]                      meta;
        logic [DXA_XLEN-1:0]                      bar_addr;
        logic [DXA_XLEN-1:0]                      smem_addr;
        logic [DXA_FLAGS_W-1:0]                   flags;
        logic [DXA_NUM_COORDS-1:0][DXA_XLEN-1:0]  coord;
    } dxa_req_t;

endpackage

// File: rtl/VX_priority_encoder.sv
// Lowest-set-bit priority encoder: index of the first asserted input and an
// any-bit-set flag.
module VX_priority_encoder #(
    parameter int N  = 4,
    parameter int LN = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  data_in,
    output logic [LN-1:0] index_out,
    output logic          valid_out
);

    always_comb begin
        index_out = '0;
        // Scan downward so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (data_in[i]) begin
                index_out = LN'(i);
            end
        end
    end

    assign valid_out = |data_in;

endmodule

// File: rtl/vx_dxa_uop_assembler.sv
// Collects the five-uop DXA launch sequence from the leader lane and packs it
// into one engine request; staging is separate from the output register.
module vx_dxa_uop_assembler
    import VX_gpu_pkg::*;
#(
    parameter int NUM_LANES  = DXA_NUM_LANES,
    parameter int XLEN       = DXA_XLEN,
    parameter int NW_WIDTH   = DXA_NW_WIDTH,
    parameter int UUID_WIDTH = DXA_UUID_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      uop_valid,
    output logic                      uop_ready,
    input  logic [2:0]                uop_op,
    input  logic [NW_WIDTH-1:0]       uop_wid,
    input  logic [UUID_WIDTH-1:0]     uop_uuid,
    input  logic [NUM_LANES-1:0]      uop_tmask,
    input  logic [NUM_LANES*XLEN-1:0] uop_rs1_data,
    input  logic [NUM_LANES*XLEN-1:0] uop_rs2_data,

    output logic                      req_valid,
    input  logic                      req_ready,
    output logic [NW_WIDTH-1:0]       req_wid,
    output logic [UUID_WIDTH-1:0]     req_uuid,
    output logic [NUM_LANES-1:0]      req_tmask,
    output logic [XLEN-1:0]           req_meta,
    output logic [XLEN-1:0]           req_bar_addr,
    output logic [XLEN-1:0]           req_smem_addr,
    output logic [DXA_FLAGS_W-1:0]    req_flags,
    output logic [5*XLEN-1:0]         req_coord,

    output logic                      seq_err
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    // Each state is named after the op it expects, so the encoding equals that op code.
    localparam logic [2:0] EXP_S0  = DXA_OP_SETUP0;
    localparam logic [2:0] EXP_S1  = DXA_OP_SETUP1;
    localparam logic [2:0] EXP_C01 = DXA_OP_COORD01;
    localparam logic [2:0] EXP_C23 = DXA_OP_COORD23;
    localparam logic [2:0] EXP_ISS = DXA_OP_ISSUE;

    logic [2:0]  state_q, state_d;
    dxa_req_t    stage_q, stage_d;
    dxa_req_t    req_q, req_d;
    logic        req_valid_q, req_valid_d;
    logic        seq_err_q, seq_err_d;

    logic [LANE_W-1:0] lead_idx;
    logic              lead_valid;
    logic [XLEN-1:0]   rs1_lane [NUM_LANES];
    logic [XLEN-1:0]   rs2_lane [NUM_LANES];
    logic [XLEN-1:0]   lead_rs1;
    logic [XLEN-1:0]   lead_rs2;

    logic uop_fire;
    logic uop_bad;

    VX_priority_encoder #(
        .N (NUM_LANES)
    ) lead_enc (
        .data_in   (uop_tmask),
        .index_out (lead_idx),
        .valid_out (lead_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign rs1_lane[gi] = uop_rs1_data[gi*XLEN +: XLEN];
            assign rs2_lane[gi] = uop_rs2_data[gi*XLEN +: XLEN];
        end
    endgenerate

    assign lead_rs1 = rs1_lane[lead_idx];
    assign lead_rs2 = rs2_lane[lead_idx];

    // ISSUE may only be taken when the output register is free or draining this cycle.
    assign uop_ready = (state_q != EXP_ISS) | ~req_valid_q | req_ready;
    assign uop_fire  = uop_valid & uop_ready;

    assign uop_bad = (uop_op != state_q)
                   | ((state_q != EXP_S0) & (uop_wid != stage_q.wid))
                   | ~lead_valid;

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        req_d       = req_q;
        req_valid_d = req_valid_q & ~req_ready;
        seq_err_d   = 1'b0;

        if (uop_fire) begin
            if ((uop_op == DXA_OP_SETUP0) & lead_valid) begin
                // A well-formed SETUP0 always (re)starts a launch, flagged if it interrupted one.
                stage_d.wid      = uop_wid;
                stage_d.uuid     = uop_uuid;
                stage_d.tmask    = uop_tmask;
                stage_d.meta     = lead_rs1;
                stage_d.bar_addr = lead_rs2;
                state_d          = EXP_S1;
                seq_err_d        = uop_bad;
            end else if (uop_bad) begin
                state_d   = EXP_S0;
                seq_err_d = 1'b1;
            end else begin
                case (state_q)
                    EXP_S1: begin
                        stage_d.smem_addr = lead_rs1;
                        stage_d.flags     = lead_rs2[XLEN-1 -: DXA_FLAGS_W];
                        state_d           = EXP_C01;
                    end
                    EXP_C01: begin
                        stage_d.coord[0] = lead_rs1;
                        stage_d.coord[1] = lead_rs2;
                        state_d          = EXP_C23;
                    end
                    EXP_C23: begin
                        stage_d.coord[2] = lead_rs1;
                        stage_d.coord[3] = lead_rs2;
                        state_d          = EXP_ISS;
                    end
                    EXP_ISS: begin
                        stage_d.coord[4] = lead_rs1;
                        req_d            = stage_d;
                        req_valid_d      = 1'b1;
                        state_d          = EXP_S0;
                    end
                    default: begin
                        state_d = EXP_S0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EXP_S0;
            stage_q     <= '0;
            req_q       <= '0;
            req_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            req_q       <= req_d;
            req_valid_q <= req_valid_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign req_valid     = req_valid_q;
    assign seq_err       = seq_err_q;
    assign req_wid       = req_q.wid;
    assign req_uuid      = req_q.uuid;
    assign req_tmask     = req_q.tmask;
    assign req_meta      = req_q.meta;
    assign req_bar_addr  = req_q.bar_addr;
    assign req_smem_addr = req_q.smem_addr;
    assign req_flags     = req_q.flags;
    assign req_coord     = req_q.coord;

endmodule

// File: tb/tb_vx_dxa_uop_assembler.sv
// Self-checking bench for vx_dxa_uop_assembler: directed vector table, hand
// sequences for backpressure and async reset, and random traffic vs a model.
module tb_vx_dxa_uop_assembler;

    localparam int NL = 4;
    localparam int XL = 32;
    localparam int NW = 4;
    localparam int UW = 44;
    localparam int PW = NW + UW + NL + 3*XL + 16 + 5*XL;

    logic              clk;
    logic              reset;
    logic              uop_valid;
    logic              uop_ready;
    logic [2:0]        uop_op;
    logic [NW-1:0]     uop_wid;
    logic [UW-1:0]     uop_uuid;
    logic [NL-1:0]     uop_tmask;
    logic [NL*XL-1:0]  uop_rs1_data;
    logic [NL*XL-1:0]  uop_rs2_data;
    logic              req_valid;
    logic              req_ready;
    logic [NW-1:0]     req_wid;
    logic [UW-1:0]     req_uuid;
    logic [NL-1:0]     req_tmask;
    logic [XL-1:0]     req_meta;
    logic [XL-1:0]     req_bar_addr;
    logic [XL-1:0]     req_smem_addr;
    logic [15:0]       req_flags;
    logic [5*XL-1:0]   req_coord;
    logic              seq_err;

    vx_dxa_uop_assembler dut (
        .clk           (clk),
        .reset         (reset),
        .uop_valid     (uop_valid),
        .uop_ready     (uop_ready),
        .uop_op        (uop_op),
        .uop_wid       (uop_wid),
        .uop_uuid      (uop_uuid),
        .uop_tmask     (uop_tmask),
        .uop_rs1_data  (uop_rs1_data),
        .uop_rs2_data  (uop_rs2_data),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wid       (req_wid),
        .req_uuid      (req_uuid),
        .req_tmask     (req_tmask),
        .req_meta      (req_meta),
        .req_bar_addr  (req_bar_addr),
        .req_smem_addr (req_smem_addr),
        .req_flags     (req_flags),
        .req_coord     (req_coord),
        .seq_err       (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_req = 0;

    // Reference model: the launch being built, what the engine sees, and the error flag.
    typedef struct {
        logic [NW-1:0] wid;
        logic [UW-1:0] uuid;
        logic [NL-1:0] tmask;
        logic [XL-1:0] meta;
        logic [XL-1:0] bar;
        logic [XL-1:0] smem;
        logic [15:0]   flags;
        logic [XL-1:0] coord [5];
    } mreq_t;

    mreq_t m_stage;
    mreq_t m_out;
    int    m_pos;
    bit    m_vld;
    bit    m_err;
    bit    s_ready;

    function automatic mreq_t blank();
        mreq_t r;
        r.wid = '0; r.uuid = '0; r.tmask = '0; r.meta = '0;
        r.bar = '0; r.smem = '0; r.flags = '0;
        for (int k = 0; k < 5; k++) r.coord[k] = '0;
        return r;
    endfunction

    function automatic logic [PW-1:0] pack_m(mreq_t r);
        return {r.wid, r.uuid, r.tmask, r.meta, r.bar, r.smem, r.flags,
                r.coord[4], r.coord[3], r.coord[2], r.coord[1], r.coord[0]};
    endfunction

    function automatic logic [PW-1:0] dut_payload();
        return {req_wid, req_uuid, req_tmask, req_meta, req_bar_addr,
                req_smem_addr, req_flags, req_coord};
    endfunction

    task automatic model_reset();
        m_stage = blank();
        m_out   = blank();
        m_pos   = 0;
        m_vld   = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: check outputs against the model, advance the model, cross the edge.
    task automatic step();
        bit fire, badu, n_vld, exp_rdy;
        int ld;
        logic [XL-1:0] v1, v2;
        @(negedge clk);
        exp_rdy = (m_pos != 4) || !m_vld || req_ready;
        s_ready = uop_ready;
        check("uop_ready", uop_ready, exp_rdy);
        check("req_valid", req_valid, m_vld);
        check("seq_err", seq_err, m_err);
        if (m_vld) check("payload", dut_payload(), pack_m(m_out));

        fire  = uop_valid && exp_rdy;
        n_vld = m_vld && !req_ready;
        if (m_vld && req_ready) begin
            n_req++;
            $display("req accepted: wid=%0d meta=%0h flags=%0h coord0=%0h coord4=%0h",
                     m_out.wid, m_out.meta, m_out.flags, m_out.coord[0], m_out.coord[4]);
        end
        m_err = 1'b0;
        if (fire) begin
            ld = -1;
            for (int l = NL - 1; l >= 0; l--) if (uop_tmask[l]) ld = l;
            v1 = (ld >= 0) ? uop_rs1_data[ld*XL +: XL] : '0;
            v2 = (ld >= 0) ? uop_rs2_data[ld*XL +: XL] : '0;
            badu = (int'(uop_op) != m_pos) || (m_pos != 0 && uop_wid != m_stage.wid) || (ld < 0);
            if (uop_op == 3'd0 && ld >= 0) begin
                m_stage.wid = uop_wid; m_stage.uuid = uop_uuid; m_stage.tmask = uop_tmask;
                m_stage.meta = v1; m_stage.bar = v2;
                m_pos = 1;
                m_err = badu;
            end else if (badu) begin
                m_pos = 0;
                m_err = 1'b1;
            end else begin
                case (m_pos)
                    1: begin m_stage.smem = v1; m_stage.flags = v2[31:16]; end
                    2: begin m_stage.coord[0] = v1; m_stage.coord[1] = v2; end
                    3: begin m_stage.coord[2] = v1; m_stage.coord[3] = v2; end
                    default: begin m_stage.coord[4] = v1; m_out = m_stage; n_vld = 1'b1; end
                endcase
                m_pos = (m_pos + 1) % 5;
            end
        end
        m_vld = n_vld;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit vld, input logic [2:0] op, input logic [NW-1:0] wid,
                         input logic [NL-1:0] tm, input int lead, input logic [XL-1:0] rs1,
                         input logic [XL-1:0] rs2, input bit rdy);
        uop_valid = vld;
        uop_op    = op;
        uop_wid   = wid;
        uop_tmask = tm;
        uop_uuid  = {12'h5a5, 32'($urandom())};
        for (int l = 0; l < NL; l++) begin
            uop_rs1_data[l*XL +: XL] = (l == lead) ? rs1 : (32'hDEAD_0000 | 32'(l));
            uop_rs2_data[l*XL +: XL] = (l == lead) ? rs2 : (32'hBEEF_0000 | 32'(l));
        end
        req_ready = rdy;
    endtask

    typedef struct {
        bit            vld;
        logic [2:0]    op;
        logic [NW-1:0] wid;
        logic [NL-1:0] tm;
        int            lead;
        logic [XL-1:0] rs1;
        logic [XL-1:0] rs2;
        bit            e_ready;
        bit            e_rv;
        bit            e_err;
        bit            chk;
        logic [NW-1:0] e_wid;
        logic [XL-1:0] e_meta;
        logic [15:0]   e_flags;
        logic [XL-1:0] e_c4;
    } row_t;

    row_t rows[$];

    task automatic add(input bit vld, input logic [2:0] op, input logic [NW-1:0] wid,
                       input logic [NL-1:0] tm, input int lead, input logic [XL-1:0] rs1,
                       input logic [XL-1:0] rs2, input bit e_rv, input bit e_err);
        row_t r;
        r.vld = vld; r.op = op; r.wid = wid; r.tm = tm; r.lead = lead;
        r.rs1 = rs1; r.rs2 = rs2; r.e_ready = 1'b1; r.e_rv = e_rv; r.e_err = e_err;
        r.chk = 1'b0; r.e_wid = '0; r.e_meta = '0; r.e_flags = '0; r.e_c4 = '0;
        rows.push_back(r);
    endtask

    task automatic expect_req(input logic [NW-1:0] w, input logic [XL-1:0] meta,
                              input logic [15:0] flags, input logic [XL-1:0] c4);
        rows[$].chk = 1'b1; rows[$].e_wid = w; rows[$].e_meta = meta;
        rows[$].e_flags = flags; rows[$].e_c4 = c4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t r;
        // Nominal launch, leader lane 1.
        add(1, 0, 2, 4'b0110, 1, 32'h10,  32'h2000,     0, 0);
        add(1, 1, 2, 4'b0110, 1, 32'h400, 32'hABCD0000, 0, 0);
        add(1, 2, 2, 4'b0110, 1, 32'h1,   32'h2,        0, 0);
        add(1, 3, 2, 4'b0110, 1, 32'h3,   32'h4,        0, 0);
        add(1, 4, 2, 4'b0110, 1, 32'h5,   32'h0,        1, 0);
        expect_req(2, 32'h10, 16'hABCD, 32'h5);
        add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        // Out-of-order op, then a clean launch on lane 3.
        add(1, 0, 1, 4'b0001, 0, 32'h11, 32'h22, 0, 0);
        add(1, 2, 1, 4'b0001, 0, 32'h33, 32'h44, 0, 1);
        add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        add(1, 0, 5, 4'b1000, 3, 32'h55, 32'h66,       0, 0);
        add(1, 1, 5, 4'b1000, 3, 32'h77, 32'h12340000, 0, 0);
        add(1, 2, 5, 4'b1000, 3, 32'h10, 32'h20,       0, 0);
        add(1, 3, 5, 4'b1000, 3, 32'h30, 32'h40,       0, 0);
        add(1, 4, 5, 4'b1000, 3, 32'h50, 32'h0,        1, 0);
        expect_req(5, 32'h55, 16'h1234, 32'h50);
        add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        // Restart by a second SETUP0 from another warp.
        add(1, 0, 1, 4'b0011, 0, 32'hA1, 32'hB1,       0, 0);
        add(1, 1, 1, 4'b0011, 0, 32'hC1, 32'h11110000, 0, 0);
        add(1, 0, 3, 4'b0100, 2, 32'hA3, 32'hB3,       0, 1);
        add(1, 1, 3, 4'b0100, 2, 32'hC3, 32'h55AA0000, 0, 0);
        add(1, 2, 3, 4'b0100, 2, 32'hD3, 32'hD4,       0, 0);
        add(1, 3, 3, 4'b0100, 2, 32'hD5, 32'hD6,       0, 0);
        add(1, 4, 3, 4'b0100, 2, 32'hE3, 32'h0,        1, 0);
        expect_req(3, 32'hA3, 16'h55AA, 32'hE3);
        add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        // Wid mismatch on COORD23; the stray ISSUE is also rejected.
        add(1, 0, 2, 4'b0010, 1, 32'h1, 32'h2, 0, 0);
        add(1, 1, 2, 4'b0010, 1, 32'h3, 32'h4, 0, 0);
        add(1, 2, 2, 4'b0010, 1, 32'h5, 32'h6, 0, 0);
        add(1, 3, 7, 4'b0010, 1, 32'h7, 32'h8, 0, 1);
        add(1, 4, 2, 4'b0010, 1, 32'h9, 32'h0, 0, 1);
        add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        // Empty mask on SETUP1.
        add(1, 0, 4, 4'b1111, 0, 32'h1, 32'h2, 0, 0);
        add(1, 1, 4, 4'b0000, 0, 32'h3, 32'h4, 0, 1);
        add(1, 2, 4, 4'b1111, 0, 32'h5, 32'h6, 0, 1);
        add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);

        reset = 1'b1;
        drive(0, 0, 0, 4'b0000, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_seq_err", seq_err, 1'b0);
        check("rst_uop_ready", uop_ready, 1'b1);
        check("rst_payload", dut_payload(), '0);
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < rows.size(); i++) begin
            r = rows[i];
            drive(r.vld, r.op, r.wid, r.tm, r.lead, r.rs1, r.rs2, 1'b1);
            step();
            check($sformatf("row%0d_ready", i), s_ready, r.e_ready);
            check($sformatf("row%0d_req_valid", i), req_valid, r.e_rv);
            check($sformatf("row%0d_seq_err", i), seq_err, r.e_err);
            if (r.chk) begin
                check($sformatf("row%0d_wid", i), req_wid, r.e_wid);
                check($sformatf("row%0d_meta", i), req_meta, r.e_meta);
                check($sformatf("row%0d_flags", i), req_flags, r.e_flags);
                check($sformatf("row%0d_coord4", i), req_coord[4*XL +: XL], r.e_c4);
            end
        end
        check("nominal_coords", req_coord, {32'hE3, 32'hD6, 32'hD5, 32'hD4, 32'hD3});

        // Backpressure: launch A waits, launch B stages behind it, B's ISSUE stalls.
        for (int k = 0; k < 5; k++) begin
            drive(1, 3'(k), 6, 4'b1100, 2, 32'hA00 + 32'(k), 32'hAA000000 + 32'(k), 0);
            step();
        end
        check("bp_a_valid", req_valid, 1'b1);
        check("bp_a_meta", req_meta, 32'hA00);
        for (int k = 0; k < 4; k++) begin
            drive(1, 3'(k), 9, 4'b0100, 2, 32'hB00 + 32'(k), 32'hBB000000 + 32'(k), 0);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            drive(1, 4, 9, 4'b0100, 2, 32'hB04, 32'h0, 0);
            step();
            check("bp_stall_ready", s_ready, 1'b0);
            check("bp_hold_meta", req_meta, 32'hA00);
        end
        drive(1, 4, 9, 4'b0100, 2, 32'hB04, 32'h0, 1);
        step();
        check("bp_release_ready", s_ready, 1'b1);
        check("bp_b_valid", req_valid, 1'b1);
        check("bp_b_meta", req_meta, 32'hB00);
        check("bp_b_coord4", req_coord[4*XL +: XL], 32'hB04);
        drive(0, 0, 0, 4'b0000, 0, 0, 0, 1);
        step();
        check("bp_drained", req_valid, 1'b0);

        // Async reset while staged in EXP_C23 with a request pending.
        for (int k = 0; k < 5; k++) begin
            drive(1, 3'(k), 1, 4'b1111, 0, 32'hC00 + 32'(k), 32'hCC000000, 0);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 3'(k), 8, 4'b1111, 0, 32'hD00 + 32'(k), 32'hDD000000, 0);
            step();
        end
        drive(0, 0, 0, 4'b0000, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_req_valid", req_valid, 1'b0);
        check("arst_payload", dut_payload(), '0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1, 3'(k), 11, 4'b1010, 1, 32'hE00 + 32'(k), 32'hEE110000, 1);
            step();
        end
        check("arst_post_valid", req_valid, 1'b1);
        check("arst_post_wid", req_wid, 4'd11);
        check("arst_post_flags", req_flags, 16'hEE11);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            uop_valid = ($urandom_range(0, 3) != 0);
            uop_op    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'(m_pos);
            uop_wid   = (m_pos == 0 || $urandom_range(0, 15) == 0) ? 4'($urandom()) : m_stage.wid;
            uop_tmask = ($urandom_range(0, 19) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            uop_uuid  = {12'($urandom()), 32'($urandom())};
            for (int l = 0; l < NL; l++) begin
                uop_rs1_data[l*XL +: XL] = $urandom();
                uop_rs2_data[l*XL +: XL] = $urandom();
            end
            req_ready = ($urandom_range(0, 1) == 1);
            step();
        end
        drive(0, 0, 0, 4'b0000, 0, 0, 0, 1);
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
